approx_seq_mult: RTL and testbench
==================================

// Module: approx_seq_mult
// PURPOSE
//   Parametrised sequential unsigned multiplier, successor to the fixed 8x8 combinational multiplier partitions.
//   Shift-add, one multiplier bit per cycle. Runtime mode select: exact or approximate.
//   Approximate mode drops the TRUNC_COLS least-significant partial-product columns.
//   Sits behind a valid/ready stream in the accuracy-exploration datapath.
// PARAMETERS
//   WIDTH       8   operand width; product is 2*WIDTH bits
//   TRUNC_COLS  4   columns zeroed in approx mode; legal range 0..WIDTH (elaboration error otherwise)
// PORTS
//   clk        in   1        single clock; all state updates on rising edge
//   rst_n      in   1        synchronous reset, active-low
//   in_valid   in   1        operands offered
//   in_ready   out  1        block can accept operands
//   in_a       in   WIDTH    multiplicand
//   in_b       in   WIDTH    multiplier
//   in_approx  in   1        1 = approximate mode, 0 = exact
//   out_valid  out  1        product available
//   out_ready  in   1        consumer takes product
//   out_p      out  2*WIDTH  product
//   busy       out  1        high in BUSY or DONE
// BEHAVIOUR
//   Reset (rst_n=0 at edge): state=IDLE; in_ready=1 after reset; out_valid=0, out_p=0, busy=0; all internal regs cleared.
//   Reset mid-operation aborts the operation; no partial result is ever presented.
//   States:
//   - IDLE: in_ready=1. in_valid&in_ready -> latch a, b, mode; acc=0; cnt=0 -> BUSY.
//   - BUSY: in_ready=0. Each cycle: if b[cnt], acc += pp(cnt); cnt++.
//     After step cnt=WIDTH-1 -> DONE.
//   - DONE: out_valid=1, out_p=acc, held stable until out_ready.
//     out_valid&out_ready -> IDLE; out_p then holds its last value, out_valid=0.
//   pp(i) = (a << i) zero-extended to 2*WIDTH.
//     In approx mode, bits [TRUNC_COLS-1:0] of pp(i) are forced 0.
//     Exact mode ignores TRUNC_COLS.
//   Approx result = sum of masked rows. It is never greater than the exact product.
//     Error is <= sum_i(min(a<<i, 2^TRUNC_COLS-1) restricted to the low columns).
//   Accumulator is 2*WIDTH bits and cannot overflow.
//   Latency: out_valid rises exactly WIDTH+1 edges after the accepting edge.
//     Next accept is possible no earlier than the cycle after the out handshake.
//   Inputs in_a/in_b/in_approx are ignored except at the accepting edge.
//     Changing them during BUSY has no effect.
//   in_valid during BUSY/DONE is not accepted (in_ready=0). The producer must hold its data.
//   TRUNC_COLS=0: approx mode equals exact mode.
//   Operands of 0 still take the full latency (no early termination).
// STRUCTURE
//   Package approx_mult_pkg:
//     state enum {IDLE, BUSY, DONE};
//     function trunc_mask(width, cols) returning the 2*WIDTH low-column mask.
//   Sub-module approx_pp_row (params WIDTH, TRUNC_COLS; in: a, idx, approx; out: masked pp).
//     Purely combinational, one instance.
//   Top holds FSM, counter ($clog2(WIDTH) bits), operand and accumulator regs.
// TESTING
//   1. Exact 13x11, out_ready=1 -> out_p=143, out_valid exactly 9 edges after accept, one-cycle pulse.
//   2. Approx 13x11 (WIDTH=8, TRUNC_COLS=4) -> out_p=112.
//      Approx 255x255 -> 64976 (exact 65025, error 49).
//   3. Backpressure: out_ready=0 for 20 cycles -> out_valid, out_p stable; in_ready=0 throughout.
//      Release -> IDLE next cycle.
//   4. Reset pulse at BUSY cycle 3 -> next cycle out_valid=0, busy=0, in_ready=1.
//      Next op 7x9 exact -> 63.
//   5. Operand change during BUSY: accept 200x3, then drive 1x1 on in_a/in_b while busy -> out_p=600.
//   6. Random sweep, both modes, WIDTH=8 and WIDTH=16 (TRUNC_COLS 0/8):
//      - out_p matches the reference model every time;
//      - approx result <= exact result;
//      - TRUNC_COLS=0 approx equals exact.

Source files
------------

// File: rtl/approx_mult_pkg.sv
// Shared state encoding and column-mask helper for the approximate sequential multiplier.
// Latency: none, types and constant functions only.
// Backpressure: not applicable.
package approx_mult_pkg;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    // Widest product the mask helper can describe (WIDTH up to 32).
    localparam int MAX_PROD_W = 64;

    // Low-column mask for a 2*width product: bits [cols-1:0] clear, the rest set.
    function automatic logic [MAX_PROD_W-1:0] trunc_mask(input int width, input int cols);
        logic [MAX_PROD_W-1:0] keep;
        logic [MAX_PROD_W-1:0] span;
        keep = {MAX_PROD_W{1'b1}} << cols;
        span = (2 * width >= MAX_PROD_W) ? {MAX_PROD_W{1'b1}}
                                         : ((64'd1 << (2 * width)) - 64'd1);
        return keep & span;
    endfunction

endpackage

// File: rtl/approx_pp_row.sv
// One partial-product row (a << idx), low TRUNC_COLS columns cleared in approx mode.
// Latency: purely combinational.
// Backpressure: none, follows its inputs.
module approx_pp_row
    import approx_mult_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int TRUNC_COLS = 4
) (
    input  logic [WIDTH-1:0]                        a,
    input  logic [((WIDTH > 1) ? $clog2(WIDTH) : 1)-1:0] idx,
    input  logic                                    approx,
    output logic [2*WIDTH-1:0]                      pp
);

    localparam logic [MAX_PROD_W-1:0] MASK_FULL = trunc_mask(WIDTH, TRUNC_COLS);
    localparam logic [2*WIDTH-1:0]    MASK      = MASK_FULL[2*WIDTH-1:0];

    logic [2*WIDTH-1:0] row;

    always_comb begin
        row = {{WIDTH{1'b0}}, a} << idx;
        pp  = approx ? (row & MASK) : row;
    end

endmodule

// File: rtl/approx_seq_mult.sv
// Shift-add unsigned multiplier, one multiplier bit per cycle, exact or low-column-truncated mode.
// Latency: out_valid rises WIDTH+1 edges after the accepting edge; one operation in flight.
// Backpressure: product held in a register until out_ready; in_ready low from accept to out handshake.
module approx_seq_mult
    import approx_mult_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int TRUNC_COLS = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    input  logic                 in_approx,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_p,
    output logic                 busy
);

    localparam int               CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

    if (TRUNC_COLS < 0 || TRUNC_COLS > WIDTH) begin : g_bad_trunc
        $error("approx_seq_mult: TRUNC_COLS must lie in 0..WIDTH");
    end
    if (2 * WIDTH > MAX_PROD_W) begin : g_bad_width
        $error("approx_seq_mult: WIDTH exceeds mask helper range");
    end

    state_t             state;
    state_t             state_nxt;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic               approx_q;
    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] pp;

    approx_pp_row #(
        .WIDTH      (WIDTH),
        .TRUNC_COLS (TRUNC_COLS)
    ) u_pp_row (
        .a      (a_q),
        .idx    (cnt),
        .approx (approx_q),
        .pp     (pp)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)              state_nxt = BUSY;
            BUSY:    if (cnt == LAST_IDX)       state_nxt = DONE;
            DONE:    if (out_valid && out_ready) state_nxt = IDLE;
            default:                            state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state == IDLE);
        busy     = (state != IDLE);
    end

    // out_valid/out_p are registered so the consumer sees glitch-free, stable outputs;
    // this register stage is the extra edge beyond the WIDTH shift-add steps.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q       <= '0;
            b_q       <= '0;
            approx_q  <= 1'b0;
            cnt       <= '0;
            acc       <= '0;
            out_valid <= 1'b0;
            out_p     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q      <= in_a;
                        b_q      <= in_b;
                        approx_q <= in_approx;
                        acc      <= '0;
                        cnt      <= '0;
                    end
                end
                BUSY: begin
                    if (b_q[cnt]) begin
                        acc <= acc + pp;
                    end
                    cnt <= cnt + CNT_W'(1);
                end
                DONE: begin
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                        out_p     <= acc;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_approx_seq_mult.sv
// Directed and random checks of approx_seq_mult at WIDTH=8 (TRUNC_COLS 4/0) and WIDTH=16 (TRUNC_COLS 8/0).
module tb_approx_seq_mult;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        in_valid, in_approx, out_ready;
    logic [7:0]  in_a, in_b;
    logic        in_ready, out_valid, busy;
    logic [15:0] out_p;
    logic        in_ready_z, out_valid_z, busy_z;
    logic [15:0] out_p_z;

    logic        in_valid16, in_approx16, out_ready16;
    logic [15:0] in_a16, in_b16;
    logic        in_ready16, out_valid16, busy16;
    logic [31:0] out_p16;
    logic        in_ready16z, out_valid16z, busy16z;
    logic [31:0] out_p16z;

    int vectors     = 0;
    int miscompares = 0;

    approx_seq_mult #(.WIDTH(8), .TRUNC_COLS(4)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_approx(in_approx), .out_valid(out_valid),
        .out_ready(out_ready), .out_p(out_p), .busy(busy));

    approx_seq_mult #(.WIDTH(8), .TRUNC_COLS(0)) dut8z (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_z),
        .in_a(in_a), .in_b(in_b), .in_approx(in_approx), .out_valid(out_valid_z),
        .out_ready(out_ready), .out_p(out_p_z), .busy(busy_z));

    approx_seq_mult #(.WIDTH(16), .TRUNC_COLS(8)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .in_ready(in_ready16),
        .in_a(in_a16), .in_b(in_b16), .in_approx(in_approx16), .out_valid(out_valid16),
        .out_ready(out_ready16), .out_p(out_p16), .busy(busy16));

    approx_seq_mult #(.WIDTH(16), .TRUNC_COLS(0)) dut16z (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .in_ready(in_ready16z),
        .in_a(in_a16), .in_b(in_b16), .in_approx(in_approx16), .out_valid(out_valid16z),
        .out_ready(out_ready16), .out_p(out_p16z), .busy(busy16z));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Sum of shifted rows with the low tc columns cleared when approx is set.
    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic approx, input int w, input int tc);
        logic [63:0] s;
        logic [63:0] row;
        s = 64'd0;
        for (int i = 0; i < w; i++) begin
            if (b[i]) begin
                row = 64'(a) << i;
                if (approx) row = row & ~((64'd1 << tc) - 64'd1);
                s = s + row;
            end
        end
        return s;
    endfunction

    // Accept one operation, scribble the inputs while busy, then wait for out_valid.
    task automatic op8(input string tag, input logic [7:0] a, input logic [7:0] b,
                       input logic approx, input logic [15:0] exp, input logic [15:0] exp_z);
        int n;
        in_a = a; in_b = b; in_approx = approx; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        in_a = 8'd1; in_b = 8'd1; in_approx = ~approx;
        n = 0;
        while (!out_valid && n < 50) begin
            tick();
            n++;
        end
        check({tag, " latency"}, 64'(n), 64'd9);
        check({tag, " p"}, 64'(out_p), 64'(exp));
        check({tag, " p_tc0"}, 64'(out_p_z), 64'(exp_z));
    endtask

    task automatic drain8(input string tag);
        tick();
        check({tag, " valid_pulse"}, 64'(out_valid), 64'd0);
        check({tag, " ready_back"}, 64'(in_ready), 64'd1);
    endtask

    task automatic op16(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic approx, input logic [31:0] exp, input logic [31:0] exp_z);
        int n;
        in_a16 = a; in_b16 = b; in_approx16 = approx; in_valid16 = 1'b1;
        tick();
        in_valid16 = 1'b0;
        in_a16 = 16'd3; in_b16 = 16'd5; in_approx16 = ~approx;
        n = 0;
        while (!out_valid16 && n < 80) begin
            tick();
            n++;
        end
        check({tag, " latency16"}, 64'(n), 64'd17);
        check({tag, " p16"}, 64'(out_p16), 64'(exp));
        check({tag, " p16_tc0"}, 64'(out_p16z), 64'(exp_z));
        tick();
        check({tag, " valid16_pulse"}, 64'(out_valid16), 64'd0);
    endtask

    initial begin
        logic [15:0] held;
        logic        stable;
        logic [7:0]  ra, rb;
        logic [15:0] ra16, rb16;
        logic [31:0] ex16;
        logic [15:0] ex8;

        rst_n = 1'b0; in_valid = 1'b0; in_approx = 1'b0; out_ready = 1'b1;
        in_a = '0; in_b = '0;
        in_valid16 = 1'b0; in_approx16 = 1'b0; out_ready16 = 1'b1;
        in_a16 = '0; in_b16 = '0;
        tick(); tick();
        check("rst in_ready", 64'(in_ready), 64'd1);
        check("rst out_valid", 64'(out_valid), 64'd0);
        check("rst out_p", 64'(out_p), 64'd0);
        check("rst busy", 64'(busy), 64'd0);
        rst_n = 1'b1;
        tick();

        op8("exact13x11", 8'd13, 8'd11, 1'b0, 16'd143, 16'd143);
        drain8("exact13x11");
        op8("approx13x11", 8'd13, 8'd11, 1'b1, 16'd112, 16'd143);
        drain8("approx13x11");
        op8("approx255x255", 8'd255, 8'd255, 1'b1, 16'd64976, 16'd65025);
        drain8("approx255x255");
        op8("scribble200x3", 8'd200, 8'd3, 1'b0, 16'd600, 16'd600);
        drain8("scribble200x3");
        op8("zero_ops", 8'd0, 8'd0, 1'b0, 16'd0, 16'd0);
        drain8("zero_ops");

        // Consumer stalls for 20 cycles while a new offer is pending.
        out_ready = 1'b0;
        op8("bp", 8'd13, 8'd11, 1'b1, 16'd112, 16'd143);
        held = out_p;
        stable = 1'b1;
        in_valid = 1'b1; in_a = 8'd99; in_b = 8'd99;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (!(out_valid === 1'b1 && out_p === held && in_ready === 1'b0 && busy === 1'b1))
                stable = 1'b0;
        end
        check("bp hold", 64'(stable), 64'd1);
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        check("bp release valid", 64'(out_valid), 64'd0);
        check("bp release in_ready", 64'(in_ready), 64'd1);
        check("bp out_p held", 64'(out_p), 64'd112);

        // Abort in the third BUSY cycle; nothing may come out afterwards.
        in_a = 8'd13; in_b = 8'd11; in_approx = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick(); tick(); tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("abort out_valid", 64'(out_valid), 64'd0);
        check("abort busy", 64'(busy), 64'd0);
        check("abort in_ready", 64'(in_ready), 64'd1);
        stable = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (out_valid !== 1'b0) stable = 1'b0;
        end
        check("abort no result", 64'(stable), 64'd1);
        op8("post_abort7x9", 8'd7, 8'd9, 1'b0, 16'd63, 16'd63);
        drain8("post_abort7x9");

        op16("exact300x300", 16'd300, 16'd300, 1'b0, 32'd90000, 32'd90000);
        op16("approx300x300", 16'd300, 16'd300, 1'b1, 32'd89600, 32'd90000);

        for (int k = 0; k < 12; k++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            op8("rnd8 exact", ra, rb, 1'b0, 16'(model(32'(ra), 32'(rb), 1'b0, 8, 4)),
                16'(model(32'(ra), 32'(rb), 1'b0, 8, 0)));
            ex8 = out_p;
            drain8("rnd8 exact");
            op8("rnd8 approx", ra, rb, 1'b1, 16'(model(32'(ra), 32'(rb), 1'b1, 8, 4)),
                16'(model(32'(ra), 32'(rb), 1'b0, 8, 0)));
            check("rnd8 approx<=exact", 64'(out_p <= ex8), 64'd1);
            drain8("rnd8 approx");
        end

        for (int k = 0; k < 6; k++) begin
            ra16 = 16'($urandom_range(0, 65535));
            rb16 = 16'($urandom_range(0, 65535));
            op16("rnd16 exact", ra16, rb16, 1'b0, 32'(model(32'(ra16), 32'(rb16), 1'b0, 16, 8)),
                 32'(model(32'(ra16), 32'(rb16), 1'b0, 16, 0)));
            ex16 = out_p16;
            op16("rnd16 approx", ra16, rb16, 1'b1, 32'(model(32'(ra16), 32'(rb16), 1'b1, 16, 8)),
                 32'(model(32'(ra16), 32'(rb16), 1'b0, 16, 0)));
            check("rnd16 approx<=exact", 64'(out_p16 <= ex16), 64'd1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
